// File: rtl/lfsr_rand_sched_pkg.sv
// Shared definitions for the LFSR random scheduler.
//   LFSR_W             : width of the shared LFSR
//   LFSR_DEFAULT_SEED  : seed used after reset, on lock-up, and for zero user seeds
//   state_e            : scheduler FSM encoding (ST_LOAD, ST_WARM, ST_IDLE, ST_SPACE)
package lfsr_rand_sched_pkg;

   localparam int          LFSR_W            = 8;
   localparam logic [7:0]  LFSR_DEFAULT_SEED = 8'hA5;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_WARM  = 2'd1,
      ST_IDLE  = 2'd2,
      ST_SPACE = 2'd3
   } state_e;

endpackage

// File: rtl/lfsr_rand_sched_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// The search starts at index ptr and wraps; the first requester found wins.
//   req     : request vector
//   ptr     : index with highest priority this round
//   gnt_oh  : one-hot winner (all zero if no request)
//   gnt_idx : binary index of the winner
//   gnt_any : at least one request present
module rr_arbiter
   import lfsr_rand_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt_oh,
   output logic [PTR_W-1:0] gnt_idx,
   output logic             gnt_any
);

   always_comb begin
      int idx;
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(ptr) + i) % N_REQ;
         if (!gnt_any && req[idx]) begin
            gnt_any     = 1'b1;
            gnt_oh[idx] = 1'b1;
            gnt_idx     = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/lfsr_rand_sched.sv
// LFSR random scheduler: seeds and warms up the external 8-bit LFSR, then hands
// one captured value per draw to a round-robin selected requester. Draws are
// spaced by SPACING shifts; an all-zero LFSR state forces a reseed.
// Ports:
//   clk, clr     : clock, asynchronous active-high reset
//   seed_in      : user seed, latched on seed_load (zero selects the default seed)
//   seed_load    : 1-cycle reseed pulse, honoured in any state
//   req          : level requests, held until own gnt bit is seen
//   gnt          : one-hot 1-cycle grant, rand_out belongs to this requester
//   rand_out     : captured LFSR value, held until the next grant
//   rand_valid   : 1-cycle pulse coincident with gnt
//   ready        : high while idle and accepting requests
//   lfsr_seed    : seed presented to the LFSR
//   lfsr_select  : 0 = LFSR loads seed, 1 = LFSR shifts
//   lfsr_out     : current LFSR state
module lfsr_rand_sched
   import lfsr_rand_sched_pkg::*;
#(
   parameter int         N_REQ        = 4,
   parameter logic [7:0] DEFAULT_SEED = LFSR_DEFAULT_SEED,
   parameter int         WARMUP       = 16,
   parameter int         SPACING      = 3
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [LFSR_W-1:0] seed_in,
   input  logic              seed_load,
   input  logic [N_REQ-1:0]  req,
   output logic [N_REQ-1:0]  gnt,
   output logic [LFSR_W-1:0] rand_out,
   output logic              rand_valid,
   output logic              ready,
   output logic [LFSR_W-1:0] lfsr_seed,
   output logic              lfsr_select,
   input  logic [LFSR_W-1:0] lfsr_out
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_e             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [LFSR_W-1:0]  seed_q, seed_d;
   logic [LFSR_W-1:0]  rand_q, rand_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic               vld_q, vld_d;
   logic               ready_q, ready_d;
   logic               sel_q, sel_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   win_q, win_d;

   logic [N_REQ-1:0]   arb_oh;
   logic [PTR_W-1:0]   arb_idx;
   logic               arb_any;
   logic               lock_up;

   // The requester granted this cycle still has req high (it drops it after
   // seeing gnt), so it is masked out to avoid a double grant.
   rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
      .req     (req & ~gnt_q),
      .ptr     (ptr_q),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   // During LOAD the LFSR output is stale (possibly cleared), so only
   // running states are checked for the all-zero trap.
   assign lock_up = (state_q != ST_LOAD) && (lfsr_out == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      seed_d  = seed_q;
      rand_d  = rand_q;
      gnt_d   = '0;
      vld_d   = 1'b0;
      ptr_d   = ptr_q;
      win_d   = win_q;

      // Reseed paths abort any in-flight draw: gnt/valid stay low, rand and
      // pointer keep their values. A user reseed outranks lock-up recovery.
      if (seed_load) begin
         seed_d  = (seed_in != '0) ? seed_in : DEFAULT_SEED;
         state_d = ST_LOAD;
      end else if (lock_up) begin
         seed_d  = DEFAULT_SEED;
         state_d = ST_LOAD;
      end else begin
         case (state_q)
            ST_LOAD: begin
               state_d = ST_WARM;
               cnt_d   = 8'(WARMUP - 1);
            end
            ST_WARM: begin
               if (cnt_q == '0) state_d = ST_IDLE;
               else             cnt_d   = cnt_q - 8'd1;
            end
            ST_IDLE: begin
               if (arb_any) begin
                  win_d   = arb_idx;
                  state_d = ST_SPACE;
                  cnt_d   = 8'(SPACING - 1);
               end
            end
            ST_SPACE: begin
               if (cnt_q == '0) begin
                  rand_d  = lfsr_out;
                  gnt_d   = N_REQ'(1) << win_q;
                  vld_d   = 1'b1;
                  ptr_d   = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            default: state_d = ST_LOAD;
         endcase
      end

      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      ready_d = (state_d == ST_IDLE);
      sel_d   = (state_d != ST_LOAD);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_LOAD;
         cnt_q   <= '0;
         seed_q  <= DEFAULT_SEED;
         rand_q  <= '0;
         gnt_q   <= '0;
         vld_q   <= 1'b0;
         ready_q <= 1'b0;
         sel_q   <= 1'b0;
         ptr_q   <= '0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         seed_q  <= seed_d;
         rand_q  <= rand_d;
         gnt_q   <= gnt_d;
         vld_q   <= vld_d;
         ready_q <= ready_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
      end
   end

   assign gnt         = gnt_q;
   assign rand_out    = rand_q;
   assign rand_valid  = vld_q;
   assign ready       = ready_q;
   assign lfsr_seed   = seed_q;
   assign lfsr_select = sel_q;

endmodule
